mips_lsu: RTL and testbench

MIPS_LSU -- requirements
Module: mips_lsu

---
 rtl/mips_pkg.sv | 30 +++
 rtl/lsu_lane.sv | 46 ++++
 rtl/mips_lsu.sv | 133 +++++++++++++
 tb/tb_mips_lsu.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared LSU definitions: FSM states, access-size codes and the RAM address limit.
package mips_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW,
    ST_WRITE,
    ST_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  // First byte address past the 256-word RAM.
  localparam logic [31:0] ADDR_LIMIT = 32'h0000_0400;

  function automatic logic lsu_access_err(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = (size == SZ_RSVD) || (addr >= ADDR_LIMIT);
    if (size == SZ_HALF && addr[0]) bad = 1'b1;
    if (size == SZ_WORD && addr[1:0] != 2'b00) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] ram_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  always_comb begin
    sh          = {offset, 3'b000};
    shifted     = ram_word >> sh;
    load_data   = ram_word;
    lane_mask   = '0;
    lane_data   = '0;
    merged_word = store_data;
    case (size)
      SZ_BYTE: begin
        load_data   = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        lane_mask   = 32'h0000_00FF << sh;
        lane_data   = {24'h0, store_data[7:0]} << sh;
        merged_word = (ram_word & ~lane_mask) | lane_data;
      end
      SZ_HALF: begin
        load_data   = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        lane_mask   = 32'h0000_FFFF << sh;
        lane_data   = {16'h0, store_data[15:0]} << sh;
        merged_word = (ram_word & ~lane_mask) | lane_data;
      end
      default: begin
        load_data   = ram_word;
        merged_word = store_data;
      end
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit driving a 256-word RAM with combinational read and synchronous write.
module mips_lsu
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [1:0]            i_size,
  input  logic                  i_signed,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_data,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ramdata
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic                  signed_q, signed_d;
  logic [1:0]            off_q, off_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
  logic [31:0]           lane_load;
  logic [31:0]           lane_merge;
  logic                  access_err;

  lsu_lane u_lane (
    .size        (size_q),
    .sign_ext    (signed_q),
    .offset      (off_q),
    .ram_word    (i_ramdata),
    .store_data  (wdata_q),
    .load_data   (lane_load),
    .merged_word (lane_merge)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    signed_d   = signed_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    access_err = lsu_access_err(i_size, i_addr);
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          we_d       = i_we;
          size_d     = i_size;
          signed_d   = i_signed;
          off_d      = i_addr[1:0];
          wdata_d    = i_wdata;
          err_d      = access_err;
          ram_addr_d = i_addr[ADDR_WIDTH+1:2];
          if (access_err) begin
            state_d = ST_DONE;
          end else if (!i_we) begin
            state_d = ST_READ;
          end else if (i_size == SZ_WORD) begin
            // Word stores skip the merge, so the write data is staged here.
            ram_data_d = i_wdata;
            state_d    = ST_WRITE;
          end else begin
            state_d = ST_RMW;
          end
        end
      end
      ST_READ: begin
        rdata_d = lane_load;
        state_d = ST_DONE;
      end
      ST_RMW: begin
        ram_data_d = lane_merge;
        state_d    = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      off_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
    end
  end

  assign o_ready    = (state_q == ST_IDLE);
  assign o_done     = (state_q == ST_DONE);
  assign o_err      = (state_q == ST_DONE) && err_q;
  assign o_ram_we   = (state_q == ST_WRITE);
  assign o_rdata    = rdata_q;
  assign o_ram_addr = ram_addr_q;
  assign o_ram_data = ram_data_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Self-checking bench for mips_lsu: directed table, reset abort, back-to-back and random traffic.
module tb_mips_lsu;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_signed;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_ram_data;
  logic        o_ram_we;
  logic [31:0] i_ramdata;

  logic [31:0] mem [256];
  logic        load_en;
  logic [7:0]  load_idx;
  logic [31:0] load_val;

  logic [31:0] ref_mem [256];
  logic [31:0] ref_rdata;

  int n_cmp;
  int n_bad;

  mips_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_size     (i_size),
    .i_signed   (i_signed),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_ready    (o_ready),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_rdata    (o_rdata),
    .o_ram_addr (o_ram_addr),
    .o_ram_data (o_ram_data),
    .o_ram_we   (o_ram_we),
    .i_ramdata  (i_ramdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_en) mem[load_idx] <= load_val;
    else if (o_ram_we) mem[o_ram_addr] <= o_ram_data;
  end
  assign i_ramdata = mem[o_ram_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-wise arithmetic on a word array.
  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic e, output logic [31:0] rd, output int lat, output int nwe);
    int unsigned nbytes, idx, off, pos;
    logic [31:0] v, w;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || (a >= 32'h400) || ((a % nbytes) != 0);
    nwe = 0;
    if (e) begin
      lat = 1;
    end else begin
      idx = a / 4;
      off = a % 4;
      w = ref_mem[idx];
      if (!we) begin
        v = 32'h0;
        for (int unsigned b = 0; b < nbytes; b++)
          v = v | (((w >> (8 * (off + b))) & 32'hFF) << (8 * b));
        if (sg && nbytes < 4 && v >= (32'd1 << (8 * nbytes - 1)))
          v = v - (32'd1 << (8 * nbytes));
        ref_rdata = v;
        lat = 2;
      end else begin
        for (int unsigned b = 0; b < nbytes; b++) begin
          pos = 8 * (off + b);
          w = (w & ~(32'hFF << pos)) | (((wd >> (8 * b)) & 32'hFF) << pos);
        end
        ref_mem[idx] = w;
        lat = (nbytes == 4) ? 2 : 3;
        nwe = 1;
      end
    end
    rd = ref_rdata;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (!o_ready && g < 10) begin
      @(negedge clk);
      g++;
    end
    if (!o_ready) chk("idle_timeout", {31'h0, o_ready}, 32'h1);
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic err, output logic [31:0] rd, output int wes);
    logic got;
    wait_idle();
    i_req = 1'b1; i_we = we; i_size = sz; i_signed = sg; i_addr = a; i_wdata = wd;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    i_we = 1'($urandom); i_size = 2'($urandom); i_signed = 1'($urandom);
    i_addr = $urandom; i_wdata = $urandom;
    lat = 1; wes = 0; got = 1'b0;
    while (!got && lat <= 8) begin
      if (o_ram_we) wes++;
      if (o_done) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!got) lat = -1;
    err = o_err;
    rd = o_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_we;
  } vec_t;

  vec_t vt[$];

  int          lat, wes, m_lat, m_we;
  logic        err, m_err;
  logic [31:0] rd, m_rd;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_size = 2'b10; i_signed = 1'b0;
    i_addr = '0; i_wdata = '0; load_en = 1'b0; load_idx = '0; load_val = '0;
    ref_rdata = 32'h0;

    #2;
    chk("rst_ready", {31'h0, o_ready}, 32'h1);
    chk("rst_done", {31'h0, o_done}, 32'h0);
    chk("rst_err", {31'h0, o_err}, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_ram_addr", {24'h0, o_ram_addr}, 32'h0);
    chk("rst_ram_data", o_ram_data, 32'h0);
    chk("rst_ram_we", {31'h0, o_ram_we}, 32'h0);

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      load_en = 1'b1; load_idx = 8'(i);
      load_val = (i == 3) ? 32'h8899AABB : $urandom;
      ref_mem[i] = load_val;
    end
    @(negedge clk);
    load_en = 1'b0;
    rst_n = 1'b1;

    vt.push_back('{1'b0, 2'd0, 1'b1, 32'h0E,  32'h0,        1'b0, 32'hFFFFFF99, 2, 0});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h0E,  32'h0,        1'b0, 32'h00000099, 2, 0});
    vt.push_back('{1'b1, 2'd1, 1'b0, 32'h0E,  32'h00001234, 1'b0, 32'h00000099, 3, 1});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        1'b0, 32'h1234AABB, 2, 0});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0D,  32'h0,        1'b1, 32'h1234AABB, 1, 0});
    vt.push_back('{1'b1, 2'd2, 1'b0, 32'h3FC, 32'hDEADBEEF, 1'b0, 32'h1234AABB, 2, 1});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'hDEADBEEF, 2, 0});
    vt.push_back('{1'b0, 2'd0, 1'b0, 32'h400, 32'h0,        1'b1, 32'hDEADBEEF, 1, 0});
    vt.push_back('{1'b1, 2'd0, 1'b0, 32'h400, 32'h77,       1'b1, 32'hDEADBEEF, 1, 0});
    vt.push_back('{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        1'b1, 32'hDEADBEEF, 1, 0});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0C,  32'h0,        1'b0, 32'hFFFFAABB, 2, 0});
    vt.push_back('{1'b0, 2'd1, 1'b0, 32'h0E,  32'h0,        1'b0, 32'h00001234, 2, 0});
    vt.push_back('{1'b0, 2'd1, 1'b1, 32'h0F,  32'h0,        1'b1, 32'h00001234, 1, 0});
    vt.push_back('{1'b1, 2'd0, 1'b0, 32'h0D,  32'hFFFFFFA5, 1'b0, 32'h00001234, 3, 1});
    vt.push_back('{1'b0, 2'd2, 1'b0, 32'h0C,  32'h0,        1'b0, 32'h1234A5BB, 2, 0});

    foreach (vt[i]) begin
      txn(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, lat, err, rd, wes);
      model(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, m_err, m_rd, m_lat, m_we);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].e_lat));
      chk($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vt[i].e_err});
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].e_rd);
      chk($sformatf("vec%0d_we_cycles", i), 32'(wes), 32'(vt[i].e_we));
    end
    chk("mem3_after_table", mem[3], 32'h1234A5BB);
    chk("mem255_after_table", mem[255], 32'hDEADBEEF);

    // Reset during the RMW cycle of a byte store must leave RAM untouched.
    wait_idle();
    i_req = 1'b1; i_we = 1'b1; i_size = 2'd0; i_signed = 1'b0; i_addr = 32'h0C; i_wdata = 32'h55;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    chk("abort_busy", {31'h0, o_ready}, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ready", {31'h0, o_ready}, 32'h1);
    chk("abort_we", {31'h0, o_ram_we}, 32'h0);
    chk("abort_rdata", o_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = 32'h0;
    wes = 0; lat = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (o_done) lat++;
      if (o_ram_we) wes++;
    end
    chk("abort_no_done", 32'(lat), 32'h0);
    chk("abort_no_write", 32'(wes), 32'h0);
    chk("abort_ready_after", {31'h0, o_ready}, 32'h1);
    chk("abort_mem3", mem[3], ref_mem[3]);

    // i_req held high: each done is followed by one IDLE cycle then acceptance.
    begin
      int   done_cyc[$];
      int   rdy_after[$];
      logic prev_done;
      wait_idle();
      i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_signed = 1'b0; i_addr = 32'h0C;
      prev_done = 1'b0;
      for (int c = 0; c < 12; c++) begin
        @(posedge clk);
        #1;
        if (prev_done) rdy_after.push_back(int'(o_ready));
        if (o_done) done_cyc.push_back(c);
        prev_done = o_done;
      end
      @(negedge clk);
      i_req = 1'b0;
      chk("b2b_done_count", 32'(done_cyc.size()), 32'd4);
      for (int k = 1; k < done_cyc.size(); k++)
        chk($sformatf("b2b_gap%0d", k), 32'(done_cyc[k] - done_cyc[k-1]), 32'd3);
      foreach (rdy_after[k])
        chk($sformatf("b2b_idle%0d", k), 32'(rdy_after[k]), 32'd1);
      chk("b2b_rdata", o_rdata, ref_mem[3]);
      ref_rdata = ref_mem[3];
    end

    for (int n = 0; n < 300; n++) begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      int          r;
      r  = $urandom_range(0, 15);
      if (r == 0) a = 32'h400 + $urandom_range(0, 63);
      else if (r == 1) a = $urandom;
      else a = $urandom_range(0, 63);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      we = 1'($urandom);
      sg = 1'($urandom);
      wd = $urandom;
      txn(we, sz, sg, a, wd, lat, err, rd, wes);
      model(we, sz, sg, a, wd, m_err, m_rd, m_lat, m_we);
      chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(m_lat));
      chk($sformatf("rnd%0d_err", n), {31'h0, err}, {31'h0, m_err});
      chk($sformatf("rnd%0d_rdata", n), rd, m_rd);
      chk($sformatf("rnd%0d_we_cycles", n), 32'(wes), 32'(m_we));
      if (we && !m_err)
        chk($sformatf("rnd%0d_mem", n), mem[a[9:2]], ref_mem[a[9:2]]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
